// File: rtl/ps2_key_decoder.sv
// PS/2 Scan Code Set 2 key decoder.
// Turns the receiver byte stream into make/break key events (queued in a
// small FIFO with a valid/ready handshake) and held-key levels for the
// arcade controls. Handles the E0/F0 prefixes, skips the Pause sequence
// and status bytes, and abandons stale prefixes after a byte timeout.
module ps2_key_decoder #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1048576
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] code,
  input  logic       valid,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic [5:0] keys,
  output logic       overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_SKIP
  } state_e;

  // Pause (E1) is followed by seven more bytes that carry no key event.
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  state_e          state_q, state_d;
  logic            valid_q;
  logic [2:0]      skip_q, skip_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [5:0]      keys_q, keys_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [9:0]      head_q, head_d;
  logic            ev_valid_q, ev_valid_d;
  logic            overflow_q, overflow_d;
  logic [9:0]      fifo_mem_q [DEPTH];

  logic            accept;
  logic            emit, emit_brk, emit_ext;
  logic            pop, push, full;
  logic [9:0]      entry;
  logic [AW-1:0]   rd_next;

  // Rising edge of the receiver's valid level: one acceptance per byte.
  assign accept = valid & ~valid_q;

  // One-hot key level for a scan code; zero when the code is not mapped.
  function automatic logic [5:0] key_mask(input logic ext, input logic [7:0] c);
    logic [5:0] m;
    m = '0;
    if (ext) begin
      case (c)
        8'h75:   m = 6'b000001;  // up
        8'h72:   m = 6'b000010;  // down
        8'h6B:   m = 6'b000100;  // left
        8'h74:   m = 6'b001000;  // right
        default: m = '0;
      endcase
    end else begin
      case (c)
        8'h29:   m = 6'b010000;  // fire (space)
        8'h5A:   m = 6'b100000;  // start (main Enter only)
        default: m = '0;
      endcase
    end
    return m;
  endfunction

  // Prefix FSM, byte timeout and key-level tracking.
  always_comb begin
    // NOTE: every signal gets a default before any branch, otherwise
    // paths that skip an assignment would infer latches.
    state_d  = state_q;
    skip_d   = skip_q;
    keys_d   = keys_q;
    emit     = 1'b0;
    emit_brk = 1'b0;
    emit_ext = 1'b0;

    tmo_d = tmo_q;
    if (accept)              tmo_d = '0;
    else if (tmo_q != TMO_MAX) tmo_d = tmo_q + TW'(1);

    if (accept) begin
      unique case (state_q)
        S_IDLE: begin
          case (code)
            8'hE0: state_d = S_EXT;
            8'hF0: state_d = S_BRK;
            8'hE1: begin
              state_d = S_SKIP;
              skip_d  = PAUSE_TAIL;
            end
            8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'h00, 8'hFF: state_d = S_IDLE;
            default: emit = 1'b1;
          endcase
        end
        S_EXT: begin
          case (code)
            8'hF0:        state_d = S_EXT_BRK;
            8'hE0:        state_d = S_EXT;
            8'h12, 8'h59: state_d = S_IDLE;  // fake shift around extended keys
            default: begin
              emit     = 1'b1;
              emit_ext = 1'b1;
              state_d  = S_IDLE;
            end
          endcase
        end
        S_BRK: begin
          emit     = 1'b1;
          emit_brk = 1'b1;
          state_d  = S_IDLE;
        end
        S_EXT_BRK: begin
          state_d = S_IDLE;
          if (code != 8'h12 && code != 8'h59) begin
            emit     = 1'b1;
            emit_brk = 1'b1;
            emit_ext = 1'b1;
          end
        end
        S_SKIP: begin
          if (skip_q <= 3'd1) begin
            state_d = S_IDLE;
            skip_d  = '0;
          end else begin
            skip_d = skip_q - 3'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && tmo_d == TMO_MAX) begin
      state_d = S_IDLE;
      skip_d  = '0;
    end

    // Levels follow every emitted event, even one the FIFO has to drop.
    if (emit) begin
      if (emit_brk) keys_d = keys_q & ~key_mask(emit_ext, code);
      else          keys_d = keys_q |  key_mask(emit_ext, code);
    end
  end

  // Event FIFO control: pointers, occupancy and registered head entry.
  always_comb begin
    entry      = {emit_brk, emit_ext, code};
    full       = (count_q == CNT_FULL);
    pop        = ev_valid_q & ev_ready;
    push       = emit & (~full | pop);
    overflow_d = emit & full & ~pop;
    rd_next    = rd_ptr_q + AW'(1);

    rd_ptr_d = pop  ? rd_next : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    head_d = head_q;
    if (pop) begin
      if (count_q > CW'(1)) head_d = fifo_mem_q[rd_next];
      else if (push)        head_d = entry;
    end else if (push && count_q == '0) begin
      head_d = entry;
    end

    ev_valid_d = (count_d != '0);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      valid_q    <= 1'b0;
      skip_q     <= '0;
      tmo_q      <= '0;
      keys_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      ev_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      valid_q    <= valid;
      skip_q     <= skip_d;
      tmo_q      <= tmo_d;
      keys_q     <= keys_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      head_q     <= head_d;
      ev_valid_q <= ev_valid_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage write port.
  // NOTE: storage is not reset; occupancy and the head register alone
  // decide what is visible, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= entry;
  end

  assign ev_valid = ev_valid_q;
  assign ev_break = head_q[9];
  assign ev_ext   = head_q[8];
  assign ev_code  = head_q[7:0];
  assign keys     = keys_q;
  assign overflow = overflow_q;

endmodule
